line_data_memory: RTL and testbench

Parametrised, byte-addressed data memory that returns a full cache line per read and accepts byte-enabled word writes over a valid/ready request port. It sits behind the cache/line-fill logic of the MIPS datapath and replaces the fixed 1 KiB, 128-bit, free-running-counter memory. All activity is on the rising clock edge, with a programmable read latency and an explicit one-cycle response strobe.

---
 rtl/line_data_memory.sv | 148 ++++++++++++++
 tb/tb_line_data_memory.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/line_data_memory.sv
// Byte-addressed data memory: full-line reads with programmable latency, byte-enabled word writes.
// Optional critical-word-first line rotation is enabled by defining LINE_MEM_CWF_EN.
module line_data_memory #(
  parameter int DEPTH_BYTES  = 1024,
  parameter int LINE_BYTES   = 16,
  parameter int READ_LATENCY = 4
) (
  input  logic                    CLk,
  input  logic                    resetN,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqWrite,
  input  logic [31:0]             address,
  input  logic [31:0]             inputData,
  input  logic [3:0]              byteEn,
  output logic                    respValid,
  output logic                    respError,
  output logic [LINE_BYTES*8-1:0] data
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int LW = $clog2(LINE_BYTES);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [AW-1:0]           base_q, base_d;
  logic                    err_q, err_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_error_q, resp_error_d;
  logic [LINE_BYTES*8-1:0] data_q, data_d;
`ifdef LINE_MEM_CWF_EN
  logic [LW-1:0]           off_q, off_d;
`endif

  // Contents survive reset; only power-up starts them at zero.
  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

  logic [31:0]             line_addr;
  logic                    rd_err;
  logic                    wr_err;
  logic                    wr_ok;
  logic [LW-1:0]           lane;
  logic [LINE_BYTES*8-1:0] line_rd;

  assign reqReady  = (state_q == IDLE);
  assign line_addr = {address[31:LW], {LW{1'b0}}};
  assign rd_err    = (line_addr >= 32'(DEPTH_BYTES));
  assign wr_err    = (address[1:0] != 2'b00) || (address >= 32'(DEPTH_BYTES));
  assign wr_ok     = resetN && reqValid && reqReady && reqWrite && !wr_err;

  always_ff @(posedge CLk) begin
    if (wr_ok) begin
      for (int n = 0; n < 4; n++) begin
        if (byteEn[n]) mem[address[AW-1:0] + AW'(n)] <= inputData[8*n +: 8];
      end
    end
  end

  // Lane n of the output takes line byte (n + critical offset) mod LINE_BYTES.
  always_comb begin
    line_rd = '0;
    lane    = '0;
    for (int n = 0; n < LINE_BYTES; n++) begin
`ifdef LINE_MEM_CWF_EN
      lane = LW'(n) + off_q;
`else
      lane = LW'(n);
`endif
      line_rd[8*n +: 8] = mem[base_q | AW'(lane)];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    data_d       = data_q;
`ifdef LINE_MEM_CWF_EN
    off_d        = off_q;
`endif
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          if (reqWrite) begin
            resp_valid_d = 1'b1;
            resp_error_d = wr_err;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(READ_LATENCY - 1);
            base_d  = line_addr[AW-1:0];
            err_d   = rd_err;
`ifdef LINE_MEM_CWF_EN
            off_d   = {address[LW-1:2], 2'b00};
`endif
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_error_d = err_q;
          data_d       = err_q ? '0 : line_rd;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLk) begin
    if (!resetN) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      data_q       <= '0;
`ifdef LINE_MEM_CWF_EN
      off_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      data_q       <= data_d;
`ifdef LINE_MEM_CWF_EN
      off_q        <= off_d;
`endif
    end
  end

  assign respValid = resp_valid_q;
  assign respError = resp_error_q;
  assign data      = data_q;

endmodule

// File: tb/tb_line_data_memory.sv
// Scoreboard bench for line_data_memory: stimulus pushes expected responses, a negedge monitor pops them.
module tb_line_data_memory;

  localparam int L = 4;

  logic         CLk = 1'b0;
  logic         resetN = 1'b0;
  logic         reqValid = 1'b0;
  logic         reqWrite = 1'b0;
  logic [31:0]  address = '0;
  logic [31:0]  inputData = '0;
  logic [3:0]   byteEn = '0;
  logic         reqReady;
  logic         respValid;
  logic         respError;
  logic [127:0] data;

  line_data_memory #(.DEPTH_BYTES(1024), .LINE_BYTES(16), .READ_LATENCY(L)) dut (
    .CLk(CLk), .resetN(resetN), .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .address(address), .inputData(inputData), .byteEn(byteEn),
    .respValid(respValid), .respError(respError), .data(data)
  );

  always #5 CLk = ~CLk;

  int cyc = 0;
  always @(posedge CLk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic         err;
    logic [127:0] line;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] last_line = '0;

  localparam logic [31:0] W0 = 32'hA0A0A0A0;
  localparam logic [31:0] W1 = 32'hB1B1B1B1;
  localparam logic [31:0] W2 = 32'hC2C2C2C2;
  localparam logic [31:0] W3 = 32'hD3D3D3D3;
  localparam logic [127:0] LINE20 = {96'h0, 32'hDDCCBBAA};
  localparam logic [127:0] LINE40 = {96'h0, 32'h11FF33FF};
`ifdef LINE_MEM_CWF_EN
  localparam logic [127:0] READ24 = {32'hDDCCBBAA, 96'h0};
  localparam logic [127:0] READ68 = {W1, W0, W3, W2};
`else
  localparam logic [127:0] READ24 = LINE20;
  localparam logic [127:0] READ68 = {W3, W2, W1, W0};
`endif

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!reqReady && n < 50) begin
      @(negedge CLk);
      n++;
    end
    check_output("req_ready", 128'(reqReady), 128'd1);
  endtask

  // Called on a negedge; returns on the negedge after the accept edge.
  task automatic apply_stimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input bit exp_err,
                                input logic [127:0] exp_line, input bit push = 1'b1);
    int acc;
    wait_ready();
    reqValid  = 1'b1;
    reqWrite  = wr;
    address   = addr;
    inputData = wdata;
    byteEn    = be;
    acc = cyc + 1;
    if (push) begin
      if (wr) sb.push_back('{exp_err, last_line, acc});
      else begin
        sb.push_back('{exp_err, exp_line, acc + L});
        last_line = exp_line;
      end
    end
    @(negedge CLk);
    reqValid = 1'b0;
  endtask

  always @(negedge CLk) begin
    exp_t e;
    if (respValid) begin
      if (sb.size() == 0) check_output("unexpected_resp", 128'd1, 128'd0);
      else begin
        e = sb.pop_front();
        check_output("resp_cycle", 128'(cyc), 128'(e.cyc));
        check_output("resp_error", 128'(respError), 128'(e.err));
        check_output("resp_data", data, e.line);
      end
    end
  end

  initial begin
    int n;
    // Reset while a write is being offered at address 0.
    resetN = 1'b0; reqValid = 1'b1; reqWrite = 1'b1; address = 32'h0;
    inputData = 32'hFFFFFFFF; byteEn = 4'hF;
    repeat (2) @(negedge CLk);
    check_output("reset_ready", 128'(reqReady), 128'd1);
    check_output("reset_valid", 128'(respValid), 128'd0);
    check_output("reset_error", 128'(respError), 128'd0);
    check_output("reset_data", data, 128'd0);
    resetN = 1'b1; reqValid = 1'b0;
    @(negedge CLk);

    apply_stimulus(0, 32'h00, 0, 0, 0, 128'd0);

    apply_stimulus(1, 32'h20, 32'hDDCCBBAA, 4'hF, 0, 0);
    apply_stimulus(0, 32'h24, 0, 0, 0, READ24);

    apply_stimulus(1, 32'h40, 32'h11223344, 4'hF, 0, 0);
    apply_stimulus(1, 32'h40, 32'hFFFFFFFF, 4'b0101, 0, 0);
    apply_stimulus(0, 32'h40, 0, 0, 0, LINE40);

    apply_stimulus(1, 32'h41, 32'h00000000, 4'hF, 1, 0);
    apply_stimulus(1, 32'h40, 32'h00000000, 4'h0, 0, 0);
    apply_stimulus(0, 32'h40, 0, 0, 0, LINE40);

    // A write offered while busy must be ignored.
    apply_stimulus(0, 32'h40, 0, 0, 0, LINE40);
    reqValid = 1'b1; reqWrite = 1'b1; address = 32'h40; inputData = 32'h0; byteEn = 4'hF;
    repeat (L - 1) @(negedge CLk);
    reqValid = 1'b0;
    apply_stimulus(0, 32'h40, 0, 0, 0, LINE40);

    apply_stimulus(0, 32'h400, 0, 0, 1, 128'd0);
    apply_stimulus(0, 32'hFFFFFFF4, 0, 0, 1, 128'd0);
    apply_stimulus(1, 32'h400, 32'h12345678, 4'hF, 1, 0);
    apply_stimulus(0, 32'h00, 0, 0, 0, 128'd0);

    // Reset two cycles into a read: no response, memory kept.
    apply_stimulus(0, 32'h20, 0, 0, 0, 0, 1'b0);
    @(negedge CLk);
    resetN = 1'b0;
    @(negedge CLk);
    resetN = 1'b1;
    last_line = '0;
    check_output("abort_data", data, 128'd0);
    check_output("abort_ready", 128'(reqReady), 128'd1);
    repeat (L + 2) @(negedge CLk);
    apply_stimulus(0, 32'h20, 0, 0, 0, LINE20);

    apply_stimulus(1, 32'h60, W0, 4'hF, 0, 0);
    apply_stimulus(1, 32'h64, W1, 4'hF, 0, 0);
    apply_stimulus(1, 32'h68, W2, 4'hF, 0, 0);
    apply_stimulus(1, 32'h6C, W3, 4'hF, 0, 0);
    apply_stimulus(0, 32'h68, 0, 0, 0, READ68);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLk);
      n++;
    end
    check_output("scoreboard_drained", 128'(sb.size()), 128'd0);
    repeat (3) @(negedge CLk);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
